// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser
//  Description : Serial-in / parallel-out deserializer. Collects WIDTH bits
//                (LSB first) framed by sync_i, then presents the word through
//                a single-entry valid/ready output stage. A word that
//                completes while the previous one is still unconsumed is
//                dropped and reported with a one-cycle overrun pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sync_i,
  input  logic             data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // Completed-word strobe and value handed from the shift side to the output stage
  logic             word_done;
  logic [WIDTH-1:0] word_new;

  // State register: all flops, synchronous reset has priority over everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic for the shift side; never stalls on the output handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    word_new  = {data_i, sr_q[WIDTH-1:1]};
    case (state_q)
      ST_IDLE: begin
        if (sync_i) begin
          // First bit enters at the MSB; WIDTH-1 further right shifts land it at bit 0
          sr_d    = {data_i, {(WIDTH-1){1'b0}}};
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          // Last bit wins over a coincident sync: the frame completes and the
          // current bit is not reused as the start of a new frame
          sr_d      = word_new;
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (sync_i) begin
          sr_d  = {data_i, {(WIDTH-1){1'b0}}};
          cnt_d = CNT_W'(1);
        end else begin
          sr_d  = word_new;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage: single-entry holding register with valid/ready handshake
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || ready_i) begin
        data_d  = word_new;
        valid_d = 1'b1;
      end else begin
        // Pending word is kept untouched; the newer one is lost
        overrun_d = 1'b1;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == ST_SHIFT);
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deser
//  Description : Scoreboard bench for sipo_deser (WIDTH=4). Stimulus pushes
//                expected words; a monitor pops and compares on handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

  localparam int WIDTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             sync_i;
  logic             data_i;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             busy_o;
  logic             overrun_o;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sync_i    (sync_i),
    .data_i    (data_i),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard queue
  always @(negedge clk_i) begin
    if (!rst_i && valid_o === 1'b1 && ready_i === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL handshake_unexpected: got %0h expected none", data_o);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          bad++;
          $display("FAIL handshake_data: got %0h expected %0h", data_o, e);
        end
      end
    end
  end

  // Apply inputs for one cycle; returns 1 ns after the consuming edge
  task automatic step(input logic s, input logic d, input logic r, input logic rs);
    sync_i  = s;
    data_i  = d;
    ready_i = r;
    rst_i   = rs;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic r);
    for (int i = 0; i < WIDTH; i++) step(i == 0, w[i], r, 1'b0);
  endtask

  initial begin
    sync_i = 1'b0; data_i = 1'b0; ready_i = 1'b0; rst_i = 1'b1;
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    check("reset_data", 16'(data_o), 16'h0);
    check("reset_valid", 16'(valid_o), 16'h0);
    check("reset_busy", 16'(busy_o), 16'h0);
    check("reset_overrun", 16'(overrun_o), 16'h0);

    // Serial data with no sync: block must stay idle
    for (int i = 0; i < 10; i++) begin
      step(0, 1'(i % 3 == 0), 1, 0);
      check("idle_quiet", {13'h0, valid_o, busy_o, overrun_o}, 16'h0);
    end

    // 1,1,0,1 with ready high -> 4'b1011 at T+4, one cycle only
    exp_q.push_back(4'b1011);
    step(1, 1, 1, 0);
    check("busy_in_frame", 16'(busy_o), 16'h1);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    check("no_early_valid", 16'(valid_o), 16'h0);
    step(0, 1, 1, 0);
    check("latency_valid", 16'(valid_o), 16'h1);
    check("latency_data", 16'(data_o), 16'hB);
    check("busy_after_frame", 16'(busy_o), 16'h0);
    step(0, 0, 1, 0);
    check("valid_cleared", 16'(valid_o), 16'h0);

    // Back-to-back A then 5 with ready low -> 5 dropped, overrun pulse
    exp_q.push_back(4'hA);
    send(4'hA, 0);
    check("hold_a_valid", 16'(valid_o), 16'h1);
    send(4'h5, 0);
    check("overrun_pulse", 16'(overrun_o), 16'h1);
    check("hold_a_data", 16'(data_o), 16'hA);
    step(0, 0, 0, 0);
    check("overrun_one_cycle", 16'(overrun_o), 16'h0);
    check("hold_a_still", {11'h0, valid_o, data_o}, 16'h1A);
    step(0, 0, 1, 0);
    check("a_consumed", 16'(valid_o), 16'h0);

    // C pending; ready rises on the very cycle 3 completes
    exp_q.push_back(4'hC);
    send(4'hC, 0);
    exp_q.push_back(4'h3);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("swap_data", 16'(data_o), 16'h3);
    check("swap_valid", 16'(valid_o), 16'h1);
    check("swap_no_overrun", 16'(overrun_o), 16'h0);
    step(0, 0, 1, 0);
    check("three_consumed", 16'(valid_o), 16'h0);

    // Two partial bits, then resync with 0,1,1,1 -> 4'hE
    exp_q.push_back(4'hE);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    send(4'hE, 1);
    check("resync_data", {11'h0, valid_o, data_o}, 16'h1E);
    step(0, 0, 1, 0);

    // Word 6 pending (ready low), reset during bit 2 of the next frame
    send(4'h6, 0);
    check("pend6_valid", 16'(valid_o), 16'h1);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    check("midreset_outputs", {11'h0, valid_o, data_o}, 16'h0);
    check("midreset_flags", {14'h0, busy_o, overrun_o}, 16'h0);
    exp_q.push_back(4'h9);
    send(4'h9, 1);
    check("post_reset_data", {11'h0, valid_o, data_o}, 16'h19);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter: WIDTH, default 4, number of serial bits per word (legal range 2..16).
REQ-002 clk_i  input  1  single clock; all logic on posedge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 sync_i  input  1  frame start; high in the cycle the first (LSB) bit of a word is present on data_i.
REQ-005 data_i  input  1  serial data, LSB first, one bit per clock.
REQ-006 ready_i  input  1  downstream accepts the word when high while valid_o is high.
REQ-007 data_o  output  WIDTH  parallel word; bit k holds the k-th received serial bit.
REQ-008 valid_o  output  1  data_o holds a complete, unconsumed word.
REQ-009 busy_o  output  1  a frame is being collected (state SHIFT).
REQ-010 overrun_o  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-011 The block shall implement two states: IDLE and SHIFT.
REQ-012 IDLE: data_i ignored; sync_i high -> capture data_i as bit 0, bit counter = 1, go to SHIFT.
REQ-013 SHIFT: each cycle capture data_i into the shift register (right shift, new bit at MSB), increment counter.
REQ-014 SHIFT: when the captured bit is bit WIDTH-1, the complete word shall be handed to the output stage on the same edge, counter cleared, state -> IDLE.
REQ-015 sync_i high while in SHIFT shall discard partial bits and restart the frame with the current data_i as bit 0 (counter = 1, stay in SHIFT).
REQ-016 sync_i high on the same cycle as the last bit of a frame shall complete that frame first (last bit counts), then the current cycle's bit is not re-used; the restart applies only if counter < WIDTH-1.
REQ-017 Latency: sync_i with bit 0 at cycle T -> valid_o high and data_o valid from cycle T+WIDTH.
REQ-018 Output stage: a handshake occurs on a cycle with valid_o and ready_i both high; valid_o shall clear after the handshake unless a new word loads on the same edge.
REQ-019 Word completes while valid_o low, or on a handshake cycle: data_o loads the new word, valid_o high next cycle.
REQ-020 Word completes while valid_o high and ready_i low: new word dropped, data_o/valid_o unchanged, overrun_o high for exactly the next cycle.
REQ-021 data_o shall remain stable while valid_o is high and no handshake has occurred.
REQ-022 busy_o shall be high exactly when state is SHIFT.
REQ-023 ready_i shall have no effect on the shift side; collection never stalls.

Reset
REQ-024 rst_i high at a clock edge shall force: state IDLE, counter 0, shift register 0, data_o 0, valid_o 0, busy_o 0, overrun_o 0.
REQ-025 Reset mid-frame shall discard partial bits; reset with valid_o high shall discard the pending word.
REQ-026 rst_i shall take priority over sync_i, ready_i and data_i in the same cycle.

Verification
REQ-027 WIDTH=4, ready_i=1, sync_i at T with serial 1,1,0,1 -> valid_o high at T+4 for one cycle, data_o=4'b1011.
REQ-028 ready_i=0, send 4'hA then 4'h5 back-to-back -> data_o stays 4'hA, valid_o stays high, overrun_o one-cycle pulse at completion of 4'h5 plus one.
REQ-029 ready_i rising on the exact cycle 4'h3 completes while 4'hC pending -> 4'hC consumed, data_o=4'h3 next cycle, valid_o stays high, no overrun.
REQ-030 sync_i after 2 bits of a frame, then 4 bits 0,1,1,1 -> data_o=4'hE; the 2 partial bits never appear.
REQ-031 rst_i asserted during bit 2 of a frame with valid_o high -> next cycle all outputs 0, busy_o 0; subsequent frame 4'h9 received correctly.
REQ-032 Serial data without sync_i for 10 cycles in IDLE -> valid_o, busy_o, overrun_o remain 0.
